// File: rtl/arb_pkg.sv
// Shared definitions for the transaction arbiter.
//   arb_state_e     : arbiter FSM states (idle search / locked transaction)
//   TXN_COUNT_WIDTH : width of the completed-transaction counter
//   wrap_inc        : modulo-n increment used for the round-robin pointer
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int TXN_COUNT_WIDTH = 16;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority search.
// Returns the first set bit of req at or after ptr, wrapping past the top.
//   req   [NUM_REQ-1:0] : request mask
//   ptr   [PTR_W-1:0]   : index where the search starts
//   idx   [PTR_W-1:0]   : selected requester (0 when nothing found)
//   found               : at least one request bit is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               found
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/txn_arbiter.sv
// Round-robin transaction arbiter: merges NUM_REQ beat streams onto one
// channel, locking the channel to one requester from grant until its last
// beat so transactions are never interleaved.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_last     : per-requester beat valid and final-beat flag
//   req_data               : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready              : per-requester beat accept
//   out_valid/out_data/
//   out_last/out_ready     : registered shared output channel
//   grant_id               : requester owning (or last owning) the channel
//   busy                   : high while a transaction is locked
//   txn_count              : transactions completed downstream, wraps
module txn_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [TXN_COUNT_WIDTH-1:0]    txn_count
);

    arb_state_e                 state;
    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            grant_q;
    logic [ID_W-1:0]            pick_idx;
    logic                       pick_found;
    logic                       out_free;
    logic                       accept;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic                       sel_last;
    logic                       vld_p1;
    logic [DATA_WIDTH-1:0]      data_p1;
    logic                       last_p1;
    logic [TXN_COUNT_WIDTH-1:0] txn_cnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The output register can take a beat when empty or draining this cycle,
    // which gives back-to-back beats without a bubble.
    assign out_free = !vld_p1 || out_ready;
    assign accept   = (state == ARB_LOCK) && req_valid[grant_q] && out_free;
    assign sel_data = req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign sel_last = req_last[grant_q];

    always_comb begin
        req_ready = '0;
        if (state == ARB_LOCK) begin
            req_ready[grant_q] = out_free;
        end
    end

    // Arbitration FSM: grant is loaded in IDLE and held until the last beat
    // is accepted; a requester that stalls mid-transaction keeps the lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state   <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (accept && sel_last) begin
                        rr_ptr <= ID_W'(wrap_inc(32'(grant_q), NUM_REQ));
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // ---- stage p1: output register ----
    // Reset clears the payload too, so a transaction cut by reset leaves
    // nothing behind on the channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            txn_cnt <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= sel_data;
                last_p1 <= sel_last;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
            if (vld_p1 && out_ready && last_p1) begin
                txn_cnt <= txn_cnt + TXN_COUNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign grant_id  = grant_q;
    assign busy      = (state == ARB_LOCK);
    assign txn_count = txn_cnt;

endmodule

// File: tb/tb_txn_arbiter.sv
module tb_txn_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ID_W       = 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_last = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic                          out_ready = 1'b1;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic [15:0]                   txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t src0[$], src1[$], src2[$], src3[$];
    beat_t exp_q[$];
    beat_t mon_e;
    beat_t drv_b;
    logic [NUM_REQ-1:0] acc;

    txn_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    function automatic int src_size(int id);
        case (id)
            0: return src0.size();
            1: return src1.size();
            2: return src2.size();
            default: return src3.size();
        endcase
    endfunction

    function automatic beat_t src_head(int id);
        case (id)
            0: return src0[0];
            1: return src1[0];
            2: return src2[0];
            default: return src3[0];
        endcase
    endfunction

    task automatic src_pop(int id);
        case (id)
            0: void'(src0.pop_front());
            1: void'(src1.pop_front());
            2: void'(src2.pop_front());
            default: void'(src3.pop_front());
        endcase
    endtask

    // Queue a beat at a requester and its expected appearance downstream.
    task automatic send(int id, logic [DATA_WIDTH-1:0] d, logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        case (id)
            0: src0.push_back(b);
            1: src1.push_back(b);
            2: src2.push_back(b);
            default: src3.push_back(b);
        endcase
        exp_q.push_back(b);
    endtask

    // One clock: score the beat leaving this cycle, then advance requesters
    // whose beat was accepted. Returns at the following falling edge.
    task automatic tick();
        #1;
        if (rst_n && out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got data=%h last=%b, required no beat", out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_last !== mon_e.last) begin
                    n_fail++;
                    $display("FAIL sb_beat: got data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, mon_e.data, mon_e.last);
                end
            end
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && src_size(i) > 0) src_pop(i);
            if (src_size(i) > 0) begin
                drv_b = src_head(i);
                req_valid[i] = 1'b1;
                req_last[i]  = drv_b.last;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = drv_b.data;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(string name, int bound);
        bit done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            tick();
            if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 &&
                src2.size() == 0 && src3.size() == 0 && out_valid === 1'b0)
                done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL rst_txn_count: got %0d, required 0", txn_count); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        send(0, 32'hA0, 1'b0);
        send(0, 32'hA1, 1'b0);
        send(0, 32'hA2, 1'b1);
        tick();
        n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle: got busy=%b ready=%b, required busy=0 ready=0000", busy, req_ready); end
        tick();
        n_checks++; if (busy !== 1'b1 || req_ready !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant: got busy=%b ready=%b id=%0d, required 1 0001 0", busy, req_ready, grant_id); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin n_fail++; $display("FAIL single_beat0: got v=%b d=%h, required v=1 d=a0", out_valid, out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin n_fail++; $display("FAIL single_beat1: got v=%b d=%h, required v=1 d=a1", out_valid, out_data); end
        tick();
        n_checks++; if (out_data !== 32'hA2 || out_last !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_beat2: got d=%h last=%b busy=%b, required a2 1 0", out_data, out_last, busy); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || txn_count !== 16'd1) begin n_fail++; $display("FAIL single_done: got v=%b count=%0d, required v=0 count=1", out_valid, txn_count); end
    endtask

    task automatic test_fairness();
        apply_reset();
        send(0, 32'h10, 1'b1);
        send(1, 32'h11, 1'b1);
        send(2, 32'h12, 1'b1);
        send(3, 32'h13, 1'b1);
        send(0, 32'h14, 1'b1);
        wait_drain("fairness", 100);
        n_checks++; if (txn_count !== 16'd5) begin n_fail++; $display("FAIL fair_count: got %0d, required 5", txn_count); end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        for (int i = 0; i < 6; i++) send(1, 32'hB0 + i, (i == 5));
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (out_valid === 1'b1 && out_data === 32'hB1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL bp_reach_b1: got no b1 within 20 cycles, required b1"); end
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hB1 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got v=%b d=%h ready=%b, required v=1 d=b1 ready=0000", s, out_valid, out_data, req_ready);
            end
        end
        out_ready = 1'b1;
        wait_drain("backpressure", 50);
        n_checks++; if (txn_count !== 16'd6) begin n_fail++; $display("FAIL bp_count: got %0d, required 6", txn_count); end
    endtask

    task automatic test_non_interleave();
        for (int i = 0; i < 4; i++) send(2, 32'hC0 + i, (i == 3));
        send(1, 32'hD0, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (busy !== 1'b1 || grant_id !== 2'd2) begin
                n_fail++;
                $display("FAIL ni_lock%0d: got busy=%b id=%0d, required busy=1 id=2", c, busy, grant_id);
            end
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ni_release: got busy=%b, required 0", busy); end
        tick();
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL ni_next: got busy=%b id=%0d, required busy=1 id=1", busy, grant_id); end
        wait_drain("non_interleave", 50);
    endtask

    task automatic test_reset_mid();
        send(0, 32'hE0, 1'b0);
        send(0, 32'hE1, 1'b0);
        send(0, 32'hE2, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got v=%b busy=%b, required 0 0", out_valid, busy); end
        n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d, required 0", txn_count); end
        src0.delete();
        src1.delete();
        src2.delete();
        src3.delete();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(i, 32'hF0 + i, 1'b1);
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got busy=%b, required 0", busy); end
        tick();
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_first_grant: got busy=%b id=%0d, required busy=1 id=0", busy, grant_id); end
        wait_drain("reset_mid", 50);
        n_checks++; if (txn_count !== 16'd4) begin n_fail++; $display("FAIL mid_count: got %0d, required 4", txn_count); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 65535; i++) send(0, DATA_WIDTH'(i), 1'b1);
        wait_drain("wrap_fill", 140000);
        n_checks++; if (txn_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full: got %h, required ffff", txn_count); end
        send(0, 32'h5A5A, 1'b1);
        wait_drain("wrap_last", 20);
        n_checks++; if (txn_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h, required 0000", txn_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_non_interleave();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
